// File: rtl/maquina_vendas.sv
// Coin-operated vending machine: product selection, coin-count payment check,
// dispense with revenue accounting, and greedy one-coin-per-cycle change output.
module maquina_vendas #(
  parameter int PRECO_1 = 50,
  parameter int PRECO_2 = 75,
  parameter int PRECO_3 = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  escolher,
  input  logic [1:0]  inserir_dinheiro,
  input  logic [1:0]  dar_troco,
  input  logic [7:0]  produto_escolhido,
  input  logic [7:0]  dinheiro_inserido,
  input  logic [7:0]  moedas_inseridas_25,
  input  logic [7:0]  moedas_inseridas_50,
  input  logic [7:0]  moedas_inseridas_100,
  output logic [7:0]  produto_liberado,
  output logic        liberar,
  output logic [1:0]  moeda_saida,
  output logic [7:0]  troco_25,
  output logic [7:0]  troco_50,
  output logic [7:0]  troco_100,
  output logic [15:0] troco,
  output logic [15:0] carteira,
  output logic        erro_produto,
  output logic        erro_moedas,
  output logic        erro_saldo,
  output logic        pronto
);

  typedef enum logic [2:0] {
    OCIOSO,
    PAGAMENTO,
    AGUARDA_TROCO,
    TROCO,
    FIM
  } state_t;

  state_t      state;
  logic [7:0]  produto;
  logic [15:0] preco;
  logic [15:0] restante;
  logic        venda_ok;

  logic [15:0] soma;
  logic [15:0] preco_sel;
  logic        produto_valido;
  logic [16:0] carteira_soma;

  always_comb begin
    soma = 16'd25  * {8'd0, moedas_inseridas_25}
         + 16'd50  * {8'd0, moedas_inseridas_50}
         + 16'd100 * {8'd0, moedas_inseridas_100};
  end

  always_comb begin
    preco_sel      = 16'd0;
    produto_valido = 1'b1;
    case (produto_escolhido)
      8'd1:    preco_sel = 16'(PRECO_1);
      8'd2:    preco_sel = 16'(PRECO_2);
      8'd3:    preco_sel = 16'(PRECO_3);
      default: produto_valido = 1'b0;
    endcase
  end

  // One extra bit so revenue overflow can be detected and clamped.
  assign carteira_soma = {1'b0, carteira} + {1'b0, preco};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= OCIOSO;
      produto          <= '0;
      preco            <= '0;
      restante         <= '0;
      venda_ok         <= 1'b0;
      produto_liberado <= '0;
      liberar          <= 1'b0;
      moeda_saida      <= '0;
      troco_25         <= '0;
      troco_50         <= '0;
      troco_100        <= '0;
      troco            <= '0;
      carteira         <= '0;
      erro_produto     <= 1'b0;
      erro_moedas      <= 1'b0;
      erro_saldo       <= 1'b0;
      pronto           <= 1'b0;
    end else begin
      liberar      <= 1'b0;
      moeda_saida  <= '0;
      erro_produto <= 1'b0;
      erro_moedas  <= 1'b0;
      erro_saldo   <= 1'b0;
      pronto       <= 1'b0;

      case (state)
        OCIOSO: begin
          if (|escolher) begin
            if (produto_valido) begin
              produto <= produto_escolhido;
              preco   <= preco_sel;
              state   <= PAGAMENTO;
            end else begin
              erro_produto <= 1'b1;
            end
          end
        end

        PAGAMENTO: begin
          if (|inserir_dinheiro) begin
            if (soma != {8'd0, dinheiro_inserido}) begin
              erro_moedas <= 1'b1;
            end else begin
              if (soma >= preco) begin
                restante <= soma - preco;
                venda_ok <= 1'b1;
              end else begin
                restante <= soma;
                venda_ok <= 1'b0;
              end
              state <= AGUARDA_TROCO;
            end
          end
        end

        AGUARDA_TROCO: begin
          if (|dar_troco) begin
            if (venda_ok) begin
              liberar          <= 1'b1;
              produto_liberado <= produto;
              carteira         <= carteira_soma[16] ? 16'hFFFF : carteira_soma[15:0];
            end else begin
              erro_saldo <= 1'b1;
            end
            troco     <= restante;
            troco_25  <= '0;
            troco_50  <= '0;
            troco_100 <= '0;
            state     <= TROCO;
          end
        end

        TROCO: begin
          if (restante == 16'd0) begin
            pronto <= 1'b1;
            state  <= FIM;
          end else if (restante >= 16'd100) begin
            moeda_saida <= 2'd3;
            restante    <= restante - 16'd100;
            troco_100   <= troco_100 + 8'd1;
          end else if (restante >= 16'd50) begin
            moeda_saida <= 2'd2;
            restante    <= restante - 16'd50;
            troco_50    <= troco_50 + 8'd1;
          end else if (restante >= 16'd25) begin
            moeda_saida <= 2'd1;
            restante    <= restante - 16'd25;
            troco_25    <= troco_25 + 8'd1;
          end else begin
            // Sub-coin remainder (only possible with non-multiple-of-25 prices) cannot be paid out.
            restante <= '0;
          end
        end

        FIM: begin
          if (!(|dar_troco)) begin
            state <= OCIOSO;
          end
        end

        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_vendas.sv
// Bench for maquina_vendas: directed vector table, hand-written corner sequences,
// and randomized transactions checked against an arithmetic model of a sale.
module tb_maquina_vendas;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  escolher, inserir_dinheiro, dar_troco;
  logic [7:0]  produto_escolhido, dinheiro_inserido;
  logic [7:0]  moedas_inseridas_25, moedas_inseridas_50, moedas_inseridas_100;
  logic [7:0]  produto_liberado;
  logic        liberar;
  logic [1:0]  moeda_saida;
  logic [7:0]  troco_25, troco_50, troco_100;
  logic [15:0] troco, carteira;
  logic        erro_produto, erro_moedas, erro_saldo, pronto;

  maquina_vendas dut (
    .clock(clock), .reset(reset),
    .escolher(escolher), .inserir_dinheiro(inserir_dinheiro), .dar_troco(dar_troco),
    .produto_escolhido(produto_escolhido), .dinheiro_inserido(dinheiro_inserido),
    .moedas_inseridas_25(moedas_inseridas_25), .moedas_inseridas_50(moedas_inseridas_50),
    .moedas_inseridas_100(moedas_inseridas_100),
    .produto_liberado(produto_liberado), .liberar(liberar), .moeda_saida(moeda_saida),
    .troco_25(troco_25), .troco_50(troco_50), .troco_100(troco_100),
    .troco(troco), .carteira(carteira),
    .erro_produto(erro_produto), .erro_moedas(erro_moedas),
    .erro_saldo(erro_saldo), .pronto(pronto)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cart_model = 0;

  typedef struct {
    int prod; int m25; int m50; int m100; int decl;
    int ex_lib; int ex_esal; int ex_troco; int ex_t25; int ex_t50; int ex_t100;
    int ex_cart; int ex_seq;
  } vec_t;
  vec_t tbl[4];

  typedef struct {
    int lib; int esal; int plib; int seq; int ncoins; int got_pronto; int cycles;
  } obs_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int preco_of(input int p);
    case (p)
      1: return 50;
      2: return 75;
      3: return 100;
      default: return 0;
    endcase
  endfunction

  task automatic select_prod(input int p, output int err);
    @(negedge clock);
    escolher = 2'($urandom_range(1, 3));
    produto_escolhido = 8'(p);
    @(posedge clock); #1;
    err = int'(erro_produto);
    escolher = 2'd0;
  endtask

  task automatic pay(input int a, input int b, input int c, input int decl, output int err);
    @(negedge clock);
    inserir_dinheiro = 2'($urandom_range(1, 3));
    moedas_inseridas_25 = 8'(a); moedas_inseridas_50 = 8'(b); moedas_inseridas_100 = 8'(c);
    dinheiro_inserido = 8'(decl);
    @(posedge clock); #1;
    err = int'(erro_moedas);
    inserir_dinheiro = 2'd0;
  endtask

  // dar_troco stays held through the whole change phase to exercise held-strobe handling.
  task automatic dispense(output obs_t o);
    @(negedge clock);
    dar_troco = 2'($urandom_range(1, 3));
    @(posedge clock); #1;
    o.lib = int'(liberar); o.esal = int'(erro_saldo); o.plib = int'(produto_liberado);
    o.seq = 0; o.ncoins = 0; o.got_pronto = 0; o.cycles = 0;
    for (int i = 0; i < 40 && o.got_pronto == 0; i++) begin
      @(posedge clock); #1;
      o.cycles++;
      if (moeda_saida != 2'd0) begin
        o.seq = o.seq * 4 + int'(moeda_saida);
        o.ncoins++;
      end
      if (pronto) o.got_pronto = 1;
    end
    chk("pronto_seen", o.got_pronto, 1);
    chk("moeda_idle_at_pronto", int'(moeda_saida), 0);
    @(posedge clock); #1;
    chk("fim_holds_no_pulse", int'(liberar | erro_saldo | pronto), 0);
    dar_troco = 2'd0;
    @(posedge clock); #1;
  endtask

  // Model: outcome of dispensing after an accepted payment `soma` for product `p`.
  task automatic check_sale(input string tag, input int p, input int soma, input obs_t o);
    int pr, ok, r, q100, q50, q25, seq;
    pr = preco_of(p);
    ok = (soma >= pr) ? 1 : 0;
    r = ok ? soma - pr : soma;
    q100 = r / 100; q50 = (r % 100) / 50; q25 = (r % 50) / 25;
    seq = 0;
    for (int k = 0; k < q100; k++) seq = seq * 4 + 3;
    for (int k = 0; k < q50; k++)  seq = seq * 4 + 2;
    for (int k = 0; k < q25; k++)  seq = seq * 4 + 1;
    if (ok) cart_model = (cart_model + pr > 65535) ? 65535 : cart_model + pr;
    chk({tag, "_liberar"}, o.lib, ok);
    chk({tag, "_erro_saldo"}, o.esal, 1 - ok);
    if (ok) chk({tag, "_produto_liberado"}, o.plib, p);
    chk({tag, "_coin_seq"}, o.seq, seq);
    chk({tag, "_pronto_cycle"}, o.cycles, q100 + q50 + q25 + 1);
    chk({tag, "_troco"}, int'(troco), r);
    chk({tag, "_troco_100"}, int'(troco_100), q100);
    chk({tag, "_troco_50"}, int'(troco_50), q50);
    chk({tag, "_troco_25"}, int'(troco_25), q25);
    chk({tag, "_carteira"}, int'(carteira), cart_model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e, soma, decl, p, a, b, c;
    obs_t o;

    tbl[0] = '{1, 0, 1, 1, 150, 1, 0, 100, 0, 0, 1, 50, 3};
    tbl[1] = '{2, 2, 1, 0, 100, 1, 0, 25, 1, 0, 0, 125, 1};
    tbl[2] = '{3, 0, 1, 0, 50,  0, 1, 50, 0, 1, 0, 125, 2};
    tbl[3] = '{3, 0, 0, 1, 100, 1, 0, 0, 0, 0, 0, 225, 0};

    reset = 1'b1;
    escolher = 0; inserir_dinheiro = 0; dar_troco = 0;
    produto_escolhido = 0; dinheiro_inserido = 0;
    moedas_inseridas_25 = 0; moedas_inseridas_50 = 0; moedas_inseridas_100 = 0;
    #12;
    chk("reset_carteira", int'(carteira), 0);
    chk("reset_troco", int'(troco), 0);
    chk("reset_pulses", int'({liberar, erro_produto, erro_moedas, erro_saldo, pronto, moeda_saida}), 0);
    chk("reset_counts", int'({produto_liberado, troco_25, troco_50, troco_100}), 0);
    @(negedge clock); reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 4; i++) begin
      select_prod(tbl[i].prod, e);
      chk("tbl_erro_produto", e, 0);
      pay(tbl[i].m25, tbl[i].m50, tbl[i].m100, tbl[i].decl, e);
      chk("tbl_erro_moedas", e, 0);
      dispense(o);
      chk("tbl_liberar", o.lib, tbl[i].ex_lib);
      chk("tbl_erro_saldo", o.esal, tbl[i].ex_esal);
      if (tbl[i].ex_lib == 1) chk("tbl_produto_liberado", o.plib, tbl[i].prod);
      chk("tbl_coin_seq", o.seq, tbl[i].ex_seq);
      chk("tbl_troco", int'(troco), tbl[i].ex_troco);
      chk("tbl_troco_25", int'(troco_25), tbl[i].ex_t25);
      chk("tbl_troco_50", int'(troco_50), tbl[i].ex_t50);
      chk("tbl_troco_100", int'(troco_100), tbl[i].ex_t100);
      chk("tbl_carteira", int'(carteira), tbl[i].ex_cart);
      $display("vector %0d prod=%0d paid=%0d liberar=%0d troco=%0d carteira=%0d",
               i, tbl[i].prod, tbl[i].decl, o.lib, troco, carteira);
    end
    cart_model = 225;

    // Wrong declared amount keeps PAGAMENTO; exact pay gives pronto on first TROCO cycle
    select_prod(1, e);
    pay(1, 0, 0, 100, e);
    chk("mismatch_erro_moedas", e, 1);
    pay(0, 1, 0, 50, e);
    chk("retry_erro_moedas", e, 0);
    dispense(o);
    check_sale("exact", 1, 50, o);
    chk("exact_first_cycle_pronto", o.cycles, 1);
    $display("sequence mismatch-retry troco=%0d carteira=%0d", troco, carteira);

    // Invalid product stays in OCIOSO; a payment strobe there is ignored
    select_prod(7, e);
    chk("bad_product_erro", e, 1);
    pay(0, 1, 0, 100, e);
    chk("idle_pay_ignored", e, 0);
    select_prod(2, e);
    chk("after_bad_select_ok", e, 0);
    pay(0, 0, 1, 100, e);
    dispense(o);
    check_sale("after_bad", 2, 100, o);
    $display("sequence bad-product then prod 2 carteira=%0d", carteira);

    // Randomized transactions against the model
    for (int t = 0; t < 30; t++) begin
      p = $urandom_range(0, 4);
      a = $urandom_range(0, 3); b = $urandom_range(0, 1); c = $urandom_range(0, 1);
      soma = 25 * a + 50 * b + 100 * c;
      decl = ($urandom_range(0, 3) == 0) ? soma + 25 : soma;
      select_prod(p, e);
      if (p < 1 || p > 3) begin
        chk("rnd_erro_produto", e, 1);
        $display("rand %0d prod=%0d rejected", t, p);
        continue;
      end
      chk("rnd_erro_produto", e, 0);
      pay(a, b, c, decl, e);
      chk("rnd_erro_moedas", e, (decl != soma) ? 1 : 0);
      if (decl != soma) begin
        pay(a, b, c, soma, e);
        chk("rnd_retry_erro_moedas", e, 0);
      end
      dispense(o);
      check_sale("rnd", p, soma, o);
      $display("rand %0d prod=%0d soma=%0d liberar=%0d troco=%0d carteira=%0d",
               t, p, soma, o.lib, troco, carteira);
    end

    // Asynchronous reset in TROCO with 175 still owed
    select_prod(1, e);
    pay(1, 0, 2, 225, e);
    chk("rst_seq_pay", e, 0);
    @(negedge clock);
    dar_troco = 2'd1;
    @(posedge clock); #1;
    chk("rst_seq_liberar", int'(liberar), 1);
    chk("rst_seq_troco", int'(troco), 175);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_liberar", int'(liberar), 0);
    chk("rst_async_troco", int'(troco), 0);
    chk("rst_async_carteira", int'(carteira), 0);
    chk("rst_async_rest", int'({produto_liberado, troco_25, troco_50, troco_100, moeda_saida, pronto}), 0);
    @(negedge clock);
    reset = 1'b0; dar_troco = 2'd0;
    cart_model = 0;
    @(posedge clock); #1;
    chk("post_reset_no_coin", int'(moeda_saida), 0);
    select_prod(2, e);
    chk("post_reset_select", e, 0);
    pay(1, 1, 0, 75, e);
    dispense(o);
    check_sale("post_reset", 2, 75, o);
    $display("sequence reset-mid-troco then prod 2 carteira=%0d", carteira);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
